// File: rtl/dram_pkg.sv
// Shared types and default constants for the data-RAM responder.
// dram_resp_t is one pending response: captured read data plus its age in cycles.
package dram_pkg;

   localparam int DRAM_XLEN    = 32;
   localparam int DRAM_MEM_AW  = 12;
   localparam int DRAM_LATENCY = 1;
   localparam int AGE_W        = 4;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   typedef struct packed {
      logic [DRAM_XLEN-1:0] rdata;
      logic [AGE_W-1:0]     age;
   } dram_resp_t;

endpackage

// File: rtl/dram_resp_fifo.sv
// In-order response queue. Every entry ages each cycle, saturating at LATENCY;
// the head is ready to retire once its age reaches LATENCY.
module dram_resp_fifo
   import dram_pkg::*;
#(
   parameter int DEPTH   = 2,
   parameter int LATENCY = DRAM_LATENCY
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic [DRAM_XLEN-1:0] push_rdata,
   input  logic                 pop,
   output logic                 full,
   output logic                 empty,
   output logic                 head_ready,
   output dram_resp_t           head
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(LATENCY);

   dram_resp_t    entries [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;

   // Explicit wrap so depths that are not a power of two stay in range.
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            entries[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (entries[i].age != AGE_MAX) begin
               entries[i].age <= entries[i].age + AGE_W'(1);
            end
         end
         // A fresh entry starts at age 1: it is visible one cycle after its accept edge.
         if (push) begin
            entries[wr_ptr].rdata <= push_rdata;
            entries[wr_ptr].age   <= AGE_W'(1);
            wr_ptr                <= next_ptr(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         if (push && !pop) begin
            count <= count + CW'(1);
         end else if (pop && !push) begin
            count <= count - CW'(1);
         end
      end
   end

   assign full       = (count == CW'(DEPTH));
   assign empty      = (count == '0);
   assign head       = entries[rd_ptr];
   assign head_ready = !empty && (head.age == AGE_MAX);

endmodule

// File: rtl/dram_responder.sv
// Data-RAM target: byte-masked word array with in-order, fixed-latency responses.
// Define DRAM_RAND_STALL_EN to add LFSR-driven random refusal of requests.
module dram_responder
   import dram_pkg::*;
#(
   parameter int XLEN        = DRAM_XLEN,
   parameter int MEM_AW      = DRAM_MEM_AW,
   parameter int LATENCY     = DRAM_LATENCY,
   parameter int OUTSTANDING = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dram_req,
   input  logic              dram_write,
   input  logic [XLEN/8-1:0] dram_wstrb,
   input  logic [XLEN-1:0]   dram_addr,
   input  logic [XLEN-1:0]   dram_wdata,
   output logic              dram_addr_ok,
   output logic              dram_data_ok,
   output logic [XLEN-1:0]   dram_rdata
);

   localparam int STRB_W = XLEN / 8;

   logic [XLEN-1:0]   mem [2**MEM_AW];
   logic [MEM_AW-1:0] word_idx;
   logic [XLEN-1:0]   push_rdata;
   logic [XLEN-1:0]   last_rdata;
   logic              accept;
   logic              pop;
   logic              full;
   logic              empty;
   logic              head_ready;
   logic              stall;
   dram_resp_t        head;
   logic              unused_ok;

`ifdef DRAM_RAND_STALL_EN
   logic [15:0] lfsr;

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr <= LFSR_SEED;
      end else begin
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      end
   end

   assign stall = (lfsr[1:0] == 2'b00);
`else
   assign stall = 1'b0;
`endif

   // Request side is valid/ready: an accept happens on a clk edge where
   // dram_req && dram_addr_ok; the initiator holds its request fields stable
   // until then. Responses carry no ready and must be taken when data_ok is high.
   assign pop          = head_ready && !rst;
   assign dram_addr_ok = dram_req && !rst && !stall && (!full || pop);
   assign accept       = dram_req && dram_addr_ok;
   assign dram_data_ok = pop;

   assign word_idx   = dram_addr[MEM_AW+1:2];
   assign push_rdata = dram_write ? '0 : mem[word_idx];

   always_ff @(posedge clk) begin
      if (accept && dram_write) begin
         for (int i = 0; i < STRB_W; i++) begin
            if (dram_wstrb[i]) begin
               mem[word_idx][8*i +: 8] <= dram_wdata[8*i +: 8];
            end
         end
      end
   end

   dram_resp_fifo #(
      .DEPTH   (OUTSTANDING),
      .LATENCY (LATENCY)
   ) u_resp_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (accept),
      .push_rdata (push_rdata),
      .pop        (pop),
      .full       (full),
      .empty      (empty),
      .head_ready (head_ready),
      .head       (head)
   );

   // Between responses the bus keeps showing the last retired data.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_rdata <= '0;
      end else if (pop) begin
         last_rdata <= head.rdata;
      end
   end

   assign dram_rdata = pop ? head.rdata : last_rdata;

   assign unused_ok = ^{dram_addr[1:0], dram_addr[XLEN-1:MEM_AW+2], head.age, empty};

endmodule

// File: tb/tb_dram_responder.sv
// Self-checking bench: instance 0 (LATENCY=1) and instance 1 (LATENCY=3), both
// OUTSTANDING=2 and MEM_AW=4, with a per-instance expected-response scoreboard.
module tb_dram_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req   [2];
   logic        wr    [2];
   logic [3:0]  strb  [2];
   logic [31:0] addr  [2];
   logic [31:0] wdata [2];
   logic        addr_ok [2];
   logic        data_ok [2];
   logic [31:0] rdata   [2];

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dram_responder #(.MEM_AW(4), .LATENCY(1), .OUTSTANDING(2)) u_dut_l1 (
      .clk(clk), .rst(rst), .dram_req(req[0]), .dram_write(wr[0]), .dram_wstrb(strb[0]),
      .dram_addr(addr[0]), .dram_wdata(wdata[0]), .dram_addr_ok(addr_ok[0]),
      .dram_data_ok(data_ok[0]), .dram_rdata(rdata[0])
   );

   dram_responder #(.MEM_AW(4), .LATENCY(3), .OUTSTANDING(2)) u_dut_l3 (
      .clk(clk), .rst(rst), .dram_req(req[1]), .dram_write(wr[1]), .dram_wstrb(strb[1]),
      .dram_addr(addr[1]), .dram_wdata(wdata[1]), .dram_addr_ok(addr_ok[1]),
      .dram_data_ok(data_ok[1]), .dram_rdata(rdata[1])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Scoreboard: push expected rdata and due cycle at each accept, pop on data_ok.
   for (genvar g = 0; g < 2; g++) begin : mon
      localparam int LAT = (g == 0) ? 1 : 3;
      logic [31:0] exp_q [$];
      int          cyc_q [$];
      logic [31:0] model_mem [16];

      always @(negedge clk) begin
         logic [3:0] idx;
         if (rst) begin
            exp_q.delete();
            cyc_q.delete();
            chk($sformatf("d%0d_data_ok_in_reset", g), {31'b0, data_ok[g]}, 32'h0);
         end else begin
            if (data_ok[g]) begin
               if (exp_q.size() == 0) begin
                  chk($sformatf("d%0d_spurious_data_ok", g), {31'b0, data_ok[g]}, 32'h0);
               end else begin
                  chk($sformatf("d%0d_rdata", g), rdata[g], exp_q.pop_front());
                  chk($sformatf("d%0d_resp_cycle", g), 32'(cyc), 32'(cyc_q.pop_front()));
               end
            end
            if (req[g] && addr_ok[g]) begin
               idx = addr[g][5:2];
               if (wr[g]) begin
                  for (int i = 0; i < 4; i++) begin
                     if (strb[g][i]) model_mem[idx][8*i +: 8] = wdata[g][8*i +: 8];
                  end
                  exp_q.push_back(32'h0);
               end else begin
                  exp_q.push_back(model_mem[idx]);
               end
               cyc_q.push_back(cyc + LAT);
            end
         end
      end
   end

   task automatic idle(input int n);
      req[0] = 1'b0;
      req[1] = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives one request and holds it until accepted; returns the accept cycle.
   task automatic issue(input int g, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s, output int acc);
      int n;
      n      = 0;
      acc    = -1;
      req[g] = 1'b1;
      wr[g]  = w;
      addr[g] = a;
      wdata[g] = d;
      strb[g] = s;
      while (acc < 0 && n < 40) begin
         @(negedge clk);
         if (addr_ok[g]) acc = cyc;
         @(posedge clk);
         #1;
         n++;
      end
      if (acc < 0) begin
         n_vec++;
         n_err++;
         $error("FAIL d%0d_accept_timeout: observed no accept expected accept within 40 cycles", g);
      end
   endtask

   initial begin
      int acc;
      int t [4];
      logic [31:0] ra;
      rst = 1'b1;
      for (int g = 0; g < 2; g++) begin
         req[g] = 1'b0; wr[g] = 1'b0; strb[g] = '0; addr[g] = '0; wdata[g] = '0;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      repeat (5) begin
         @(negedge clk);
         for (int g = 0; g < 2; g++) begin
            chk($sformatf("d%0d_reset_addr_ok", g), {31'b0, addr_ok[g]}, 32'h0);
            chk($sformatf("d%0d_reset_data_ok", g), {31'b0, data_ok[g]}, 32'h0);
            chk($sformatf("d%0d_reset_rdata", g), rdata[g], 32'h0);
         end
         @(posedge clk);
         #1;
      end

      // Full-word write then back-to-back read of the same word.
      issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, t[0]);
      issue(0, 1'b0, 32'h10, 32'h0, 4'h0, t[1]);
      chk("d0_b2b_accept_gap", 32'(t[1] - t[0]), 32'h1);
      idle(3);

      // Single byte lane update, then read back.
      issue(0, 1'b1, 32'h11, 32'h55555555, 4'b0010, acc);
      issue(0, 1'b0, 32'h10, 32'h0, 4'h0, acc);
      idle(3);

      // 0x40 aliases word 0 with a 4-bit word address.
      issue(0, 1'b1, 32'h40, 32'h12345678, 4'hF, acc);
      issue(0, 1'b0, 32'h00, 32'h0, 4'h0, acc);
      idle(3);

      // LATENCY=3 instance: preload four words, then four held reads.
      for (int i = 0; i < 4; i++) begin
         issue(1, 1'b1, 32'(i * 4), 32'hA0A0_0000 | 32'(i), 4'hF, acc);
      end
      idle(6);
      for (int i = 0; i < 4; i++) begin
         issue(1, 1'b0, 32'(i * 4), 32'h0, 4'h0, t[i]);
      end
      idle(6);
      chk("d1_accept1_gap", 32'(t[1] - t[0]), 32'd1);
      chk("d1_accept2_gap_full", 32'(t[2] - t[0]), 32'd3);
      chk("d1_accept3_gap", 32'(t[3] - t[0]), 32'd4);

      // Random traffic on the LATENCY=1 instance with aliased addresses.
      for (int i = 0; i < 16; i++) begin
         issue(0, 1'b1, ($urandom() & 32'hFFFF_FFC3) | 32'(i << 2), $urandom(), 4'hF, acc);
      end
      for (int i = 0; i < 30; i++) begin
         ra = $urandom();
         issue(0, 1'($urandom_range(0, 1)), ra, $urandom(), 4'($urandom_range(0, 15)), acc);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      idle(4);

      // Reset with reads pending: they are dropped, the earlier write survives.
      issue(1, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, acc);
      issue(1, 1'b0, 32'h20, 32'h0, 4'h0, acc);
      issue(1, 1'b0, 32'h20, 32'h0, 4'h0, acc);
      req[1] = 1'b0;
      rst = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      idle(8);
      issue(1, 1'b0, 32'h20, 32'h0, 4'h0, acc);
      idle(6);

      chk("d0_queue_drained", 32'(mon[0].exp_q.size()), 32'h0);
      chk("d1_queue_drained", 32'(mon[1].exp_q.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
